ycc_dct_scheduler: RTL
======================

// Module: ycc_dct_scheduler
// PURPOSE
//  Buffers the three colour-transform output streams (Y, Cb, Cr; data+valid, no backpressure).
//  Time-multiplexes them onto the single shared DCT row input, in fixed-length bursts.
//  Sits between RGB2YCbCr and the row DCT; arbitration is round-robin over ready channels.
// PARAMETERS
//  DATA_W    10  sample width, matches the colour-transform output width
//  BURST_LEN 8   samples per grant (one DCT row)
//  DEPTH     32  per-channel FIFO depth in samples; must satisfy DEPTH >= BURST_LEN (checked at elaboration)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous, active-high reset
//  in_data    in   3 x DATA_W   per-channel sample; index 0=Y, 1=Cb, 2=Cr
//  in_valid   in   3            per-channel write strobe, one sample per cycle per channel
//  out_data   out  DATA_W       sample presented to the DCT
//  out_valid  out  1            out_data valid
//  out_ready  in   1            DCT accepts a beat when out_valid && out_ready
//  out_ch     out  2            channel of the current burst (0/1/2)
//  out_first  out  1            high on beat 0 of a burst
//  out_last   out  1            high on beat BURST_LEN-1 of a burst
//  ovf        out  3            sticky per-channel overflow flag
// BEHAVIOUR
//  Reset (async, immediate):
//   - all FIFOs emptied; state=IDLE; rr_ptr=0.
//   - out_valid, out_first, out_last, out_ch, out_data and ovf all 0.
//  FIFOs: one per channel, first-word-fall-through.
//   - count width is $clog2(DEPTH+1).
//   - Push and pop in the same cycle leave count unchanged.
//   - Push while count==DEPTH with no pop that cycle: sample dropped, ovf[ch] set; ovf clears only on reset.
//   - Push at full with a concurrent pop: accepted.
//  FSM states: IDLE, BURST.
//   - IDLE: scan channels in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
//     - First channel with count >= BURST_LEN is granted: cur_ch latched, beat=0, go to BURST.
//     - No eligible channel: stay in IDLE.
//   - BURST: out_valid=1, out_ch=cur_ch, out_data=head of fifo[cur_ch].
//     - out_first = (beat==0); out_last = (beat==BURST_LEN-1).
//     - On out_valid && out_ready: pop fifo[cur_ch] and increment beat.
//     - On the accepted last beat: rr_ptr = (cur_ch+1) mod 3, go to IDLE.
//   - Exactly one IDLE cycle (out_valid=0) separates consecutive bursts.
//  Handshake:
//   - While out_valid && !out_ready, out_data/out_ch/out_first/out_last are held stable.
//   - A burst is never abandoned; it cannot underflow because count >= BURST_LEN at grant and only
//     this block pops.
//  Latency: out_valid rises on the clock edge after the edge that wrote the BURST_LEN-th sample
//   (IDLE state, channel eligible).
//  Inputs keep being written into all FIFOs, including the one being read, during a burst.
//  Reset mid-burst: the burst is aborted and its buffered data discarded; nothing is emitted until
//   BURST_LEN new samples arrive.
// TESTING
//  1 Single channel: out_ready=1; write Y 0..7 on consecutive cycles.
//    -> one burst, out_ch=0, data 0..7; out_first on 0, out_last on 7;
//       out_valid rises one edge after the 8th write.
//  2 All channels: write Y=i, Cb=100+i, Cr=200+i (i=0..7) simultaneously.
//    -> bursts in order ch0, ch1, ch2 with data as written; exactly 1 idle cycle between bursts.
//  3 Round-robin: Y gets 16 samples (0..15), Cb gets 8 (50..57), all before the first grant.
//    -> order Y(0..7), Cb(50..57), Y(8..15).
//  4 Backpressure: one Y burst with out_ready pattern 1,0,1,0,...
//    -> data 0..7 each accepted exactly once, outputs stable while stalled, out_last only on value 7.
//  5 Overflow: DEPTH=16, out_ready=0, write Y 0..16.
//    -> ovf=3'b001 after the 17th write; after out_ready=1, two bursts 0..7 and 8..15, no 16;
//       ovf stays set.
//  6 Reset mid-burst: assert rst after beat 3 accepted.
//    -> out_valid=0 immediately; ovf cleared; after release, no output until 8 new samples,
//       which then emerge as a fresh burst from ch0.

Source files
------------

// File: rtl/ycc_dct_scheduler.sv
// Buffers the Y/Cb/Cr colour-transform streams in per-channel FIFOs and
// multiplexes them onto the shared row-DCT input in fixed-length, round-robin bursts.
module ycc_dct_scheduler #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned DEPTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0][DATA_W-1:0] in_data,
  input  logic [2:0]             in_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_ch,
  output logic                   out_first,
  output logic                   out_last,
  output logic [2:0]             ovf
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if (DEPTH < BURST_LEN) begin : g_depth_check
    $error("ycc_dct_scheduler: DEPTH must be >= BURST_LEN");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_d;
  logic [1:0]          rr_ptr, rr_d;
  logic [1:0]          cur_ch, cur_ch_d;
  logic [BEAT_W-1:0]   beat, beat_d;
  logic                valid_d, first_d, last_d;
  logic [DATA_W-1:0]   data_d;
  logic [1:0]          cand;
  logic                found;

  logic [DATA_W-1:0]   mem      [NCH][DEPTH];
  logic [PTR_W-1:0]    wr_ptr   [NCH];
  logic [PTR_W-1:0]    rd_ptr   [NCH];
  logic [CNT_W-1:0]    count    [NCH];
  logic [DATA_W-1:0]   head     [NCH];
  logic [DATA_W-1:0]   head_nxt [NCH];
  logic [NCH-1:0]      push, pop, ovf_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_ch = cur_ch;

  // A push into a full FIFO is only accepted when the same cycle pops it.
  always_comb begin
    push    = '0;
    pop     = '0;
    ovf_set = '0;
    for (int i = 0; i < NCH; i++) begin
      pop[i]     = out_valid && out_ready && (cur_ch == 2'(i));
      push[i]    = in_valid[i] && ((count[i] != CNT_W'(DEPTH)) || pop[i]);
      ovf_set[i] = in_valid[i] && (count[i] == CNT_W'(DEPTH)) && !pop[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      head[i]     = mem[i][rd_ptr[i]];
      head_nxt[i] = mem[i][ptr_inc(rd_ptr[i])];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        unique case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: ;
        endcase
      end
      ovf <= ovf | ovf_set;
    end
  end

  // Output registers are loaded one beat ahead from the FIFO head so they hold under stall.
  always_comb begin
    state_d  = state;
    rr_d     = rr_ptr;
    cur_ch_d = cur_ch;
    beat_d   = beat;
    valid_d  = out_valid;
    first_d  = out_first;
    last_d   = out_last;
    data_d   = out_data;
    cand     = '0;
    found    = 1'b0;
    unique case (state)
      IDLE: begin
        for (int k = 0; k < NCH; k++) begin
          cand = 2'((int'(rr_ptr) + k) % 3);
          if (!found && (count[cand] >= CNT_W'(BURST_LEN))) begin
            found    = 1'b1;
            state_d  = BURST;
            cur_ch_d = cand;
            beat_d   = '0;
            valid_d  = 1'b1;
            first_d  = 1'b1;
            last_d   = (BURST_LEN == 1);
            data_d   = head[cand];
          end
        end
      end
      BURST: begin
        if (out_ready) begin
          if (beat == BEAT_W'(BURST_LEN - 1)) begin
            state_d = IDLE;
            rr_d    = (cur_ch == 2'd2) ? 2'd0 : cur_ch + 2'd1;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            beat_d  = beat + BEAT_W'(1);
            first_d = 1'b0;
            last_d  = ((beat + BEAT_W'(1)) == BEAT_W'(BURST_LEN - 1));
            data_d  = head_nxt[cur_ch];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_d;
      cur_ch    <= cur_ch_d;
      beat      <= beat_d;
      out_valid <= valid_d;
      out_first <= first_d;
      out_last  <= last_d;
      out_data  <= data_d;
    end
  end

endmodule
